sram_core_responder: RTL and testbench

- Responder end of the core_mem request/wait interface that the recognition datapath issues as initiator.
- Accepts one-word read/write requests from the core and sequences the external async 16-bit SRAM pins (CE/OE/WE/LB/UB/ADDR/DQ) with a programmable access length.
- Returns read data and a Moore-style core_wait.
- Sits between recognition_top's memory port and the board SRAM.

---
 rtl/sram_pkg.sv | 23 ++
 rtl/sram_dq_buffer.sv | 43 ++++
 rtl/sram_core_responder.sv | 135 +++++++++++++
 tb/tb_sram_core_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the core_mem to async SRAM responder.
package sram_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;
    localparam int SRAM_CNT_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } sram_state_t;

    // Counter preload: the counter reaches zero in the last active strobe cycle.
    function automatic logic [SRAM_CNT_W-1:0] access_count(
        input int unsigned access_cycles,
        input logic [1:0]  timing
    );
        return SRAM_CNT_W'(access_cycles - 32'd1) + SRAM_CNT_W'(timing);
    endfunction

endpackage

// File: rtl/sram_dq_buffer.sv
// Tristate driver and read-capture register for the SRAM data bus.
module sram_dq_buffer
    import sram_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              load,
    input  logic [DATA_W-1:0] wdata,
    input  logic              oe_next,
    input  logic              capture,
    inout  wire  [DATA_W-1:0] io_dq,
    output logic [DATA_W-1:0] r_value,
    output logic              dq_oe
);

    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] rdata_r;
    logic              oe_r;

    // Write-data latch, registered output enable and read capture.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wdata_r <= {DATA_W{1'b0}};
            rdata_r <= {DATA_W{1'b0}};
            oe_r    <= 1'b0;
        end else begin
            if (load) begin
                wdata_r <= wdata;
            end
            if (capture) begin
                rdata_r <= io_dq;
            end
            oe_r <= oe_next;
        end
    end

    assign io_dq   = oe_r ? wdata_r : {DATA_W{1'bz}};
    assign r_value = rdata_r;
    assign dq_oe   = oe_r;

endmodule

// File: rtl/sram_core_responder.sv
// core_mem responder sequencing an async 16-bit SRAM with programmable access length.
module sram_core_responder
    import sram_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = SRAM_ADDR_W,
    parameter int DATA_W        = SRAM_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_input_timing,
    input  logic              core_mem_request,
    input  logic              core_mem_wr,
    input  logic [ADDR_W-1:0] core_mem_addr,
    input  logic [DATA_W-1:0] core_mem_w_value,
    output logic [DATA_W-1:0] core_mem_r_value,
    output logic              core_wait,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N,
    inout  wire  [DATA_W-1:0] io_SRAM_DQ
);

    sram_state_t           state_r, next_s;
    logic [SRAM_CNT_W-1:0] cnt_r, cnt_next_s;
    logic                  accept_s, capture_s;
    logic                  ce_n_s, oe_n_s, we_n_s, be_n_s, dq_oe_next_s;
    logic                  dq_oe_s;

    // Next-state and access counter.
    always_comb begin
        next_s     = state_r;
        cnt_next_s = cnt_r;
        accept_s   = 1'b0;
        capture_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (core_mem_request) begin
                    accept_s   = 1'b1;
                    next_s     = core_mem_wr ? S_WRITE : S_READ;
                    cnt_next_s = access_count(ACCESS_CYCLES, i_input_timing);
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_READ: begin
                if (cnt_r == {SRAM_CNT_W{1'b0}}) begin
                    capture_s = 1'b1;
                    next_s    = S_DONE;
                end else begin
                    cnt_next_s = cnt_r - {{(SRAM_CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_WRITE: begin
                if (cnt_r == {SRAM_CNT_W{1'b0}}) begin
                    next_s = S_DONE;
                end else begin
                    cnt_next_s = cnt_r - {{(SRAM_CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_DONE:  next_s = S_IDLE;
            default: next_s = S_IDLE;
        endcase
    end

    // Strobe values for the upcoming state; DQ stays driven one cycle past a write.
    always_comb begin
        ce_n_s       = 1'b1;
        oe_n_s       = 1'b1;
        we_n_s       = 1'b1;
        be_n_s       = 1'b1;
        dq_oe_next_s = 1'b0;
        case (next_s)
            S_READ: begin
                ce_n_s = 1'b0;
                oe_n_s = 1'b0;
                be_n_s = 1'b0;
            end
            S_WRITE: begin
                ce_n_s       = 1'b0;
                we_n_s       = 1'b0;
                be_n_s       = 1'b0;
                dq_oe_next_s = 1'b1;
            end
            S_DONE:  dq_oe_next_s = (state_r == S_WRITE);
            S_IDLE:  dq_oe_next_s = 1'b0;
            default: dq_oe_next_s = 1'b0;
        endcase
    end

    // State, counter, address and strobe registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= S_IDLE;
            cnt_r       <= {SRAM_CNT_W{1'b0}};
            o_SRAM_ADDR <= {ADDR_W{1'b0}};
            o_SRAM_CE_N <= 1'b1;
            o_SRAM_OE_N <= 1'b1;
            o_SRAM_WE_N <= 1'b1;
            o_SRAM_LB_N <= 1'b1;
            o_SRAM_UB_N <= 1'b1;
        end else begin
            state_r     <= next_s;
            cnt_r       <= cnt_next_s;
            if (accept_s) begin
                o_SRAM_ADDR <= core_mem_addr;
            end
            o_SRAM_CE_N <= ce_n_s;
            o_SRAM_OE_N <= oe_n_s;
            o_SRAM_WE_N <= we_n_s;
            o_SRAM_LB_N <= be_n_s;
            o_SRAM_UB_N <= be_n_s;
        end
    end

    assign core_wait = (state_r != S_DONE);

    sram_dq_buffer #(
        .DATA_W (DATA_W)
    ) u_dq (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .load    (accept_s),
        .wdata   (core_mem_w_value),
        .oe_next (dq_oe_next_s),
        .capture (capture_s),
        .io_dq   (io_SRAM_DQ),
        .r_value (core_mem_r_value),
        .dq_oe   (dq_oe_s)
    );

endmodule

// File: tb/tb_sram_core_responder.sv
// Bench for sram_core_responder: vector table, scoreboard, SRAM model, bus-safety monitor.
module tb_sram_core_responder;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [1:0]  i_input_timing;
    logic        core_mem_request, core_mem_wr;
    logic [19:0] core_mem_addr;
    logic [15:0] core_mem_w_value, core_mem_r_value;
    logic        core_wait;
    logic [19:0] sram_addr;
    logic        we_n, ce_n, oe_n, lb_n, ub_n;
    wire  [15:0] sram_dq;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] mem [0:255];
    logic [15:0] exp_mem [0:255];
    logic        mem_fill;
    logic [15:0] sb_q [$];
    logic [15:0] tr_we, tr_oe, tr_dqoe;

    always #5 i_clk = ~i_clk;

    sram_core_responder dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_input_timing   (i_input_timing),
        .core_mem_request (core_mem_request),
        .core_mem_wr      (core_mem_wr),
        .core_mem_addr    (core_mem_addr),
        .core_mem_w_value (core_mem_w_value),
        .core_mem_r_value (core_mem_r_value),
        .core_wait        (core_wait),
        .o_SRAM_ADDR      (sram_addr),
        .o_SRAM_WE_N      (we_n),
        .o_SRAM_CE_N      (ce_n),
        .o_SRAM_OE_N      (oe_n),
        .o_SRAM_LB_N      (lb_n),
        .o_SRAM_UB_N      (ub_n),
        .io_SRAM_DQ       (sram_dq)
    );

    // Async SRAM model: drives the bus on reads, stores while WE_N is low.
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'bz;
    always @(posedge i_clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'(i + 256);
        end else if (!ce_n && !we_n && !lb_n && !ub_n) begin
            mem[sram_addr[7:0]] <= sram_dq;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus safety monitor, every cycle outside reset.
    always @(negedge i_clk) begin
        if (i_rst === 1'b0) begin
            chk("dq_vs_oe", {31'd0, dut.dq_oe_s && !oe_n}, 32'd0);
            chk("we_vs_ce", {31'd0, !we_n && ce_n}, 32'd0);
        end
    end

    // One transaction starting at a negedge; returns the edge count to completion.
    task automatic do_txn(input logic wr, input logic [19:0] a, input logic [15:0] wd,
                          input logic [1:0] t, input logic [15:0] exp_rd,
                          input int tchg, input int drop_at, output int lat);
        logic done;
        core_mem_request = 1'b1;
        core_mem_wr      = wr;
        core_mem_addr    = a;
        core_mem_w_value = wd;
        i_input_timing   = t;
        if (!wr) sb_q.push_back(exp_rd);
        tr_we = 16'd0; tr_oe = 16'd0; tr_dqoe = 16'd0;
        lat = 0; done = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            if (k == tchg) i_input_timing = 2'd0;
            if (k < 16) begin
                tr_we[k] = !we_n; tr_oe[k] = !oe_n; tr_dqoe[k] = dut.dq_oe_s;
            end
            if (k == 1) chk("addr", {12'd0, sram_addr}, {12'd0, a});
            if (k == 1 && wr) chk("dq_drive", {16'd0, sram_dq}, {16'd0, wd});
            if (!core_wait) begin
                lat = k; done = 1'b1;
                if (wr) begin
                    chk("dq_hold", {16'd0, sram_dq}, {16'd0, wd});
                end else if (sb_q.size() == 0) begin
                    chk("sb_empty", 32'd1, 32'd0);
                end else begin
                    chk("r_value", {16'd0, core_mem_r_value}, {16'd0, sb_q.pop_front()});
                end
            end
            if (k == drop_at || done) core_mem_request = 1'b0;
        end
        if (!done) chk("timeout", 32'd1, 32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        if (lat + 1 < 16) begin
            tr_we[lat+1] = !we_n; tr_oe[lat+1] = !oe_n; tr_dqoe[lat+1] = dut.dq_oe_s;
        end
    endtask

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [15:0] data;
        logic [1:0]  timing;
        int          exp_lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat, cyc, last, compl;
        logic [15:0] e_we, e_oe, e_dq;
        logic        idle_next;
        vecs[0] = '{1'b1, 20'h00123, 16'hBEEF, 2'd0, 3};
        vecs[1] = '{1'b0, 20'h00123, 16'hBEEF, 2'd0, 3};
        vecs[2] = '{1'b1, 20'h00044, 16'h1234, 2'd3, 6};
        vecs[3] = '{1'b0, 20'h00044, 16'h1234, 2'd3, 6};
        vecs[4] = '{1'b0, 20'h00002, 16'h0102, 2'd1, 4};
        vecs[5] = '{1'b1, 20'hFFFFF, 16'hA5A5, 2'd2, 5};
        vecs[6] = '{1'b0, 20'hFFFFF, 16'hA5A5, 2'd0, 3};
        for (int i = 0; i < 256; i++) exp_mem[i] = 16'(i + 256);

        // Reset held with a pending request.
        i_rst = 1'b1; mem_fill = 1'b1;
        core_mem_request = 1'b1; core_mem_wr = 1'b0; core_mem_addr = 20'd5;
        core_mem_w_value = 16'd0; i_input_timing = 2'd0;
        for (int c = 0; c < 3; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            chk("rst_strobes", {27'd0, we_n, ce_n, oe_n, lb_n, ub_n}, 32'h1F);
            chk("rst_idle", {29'd0, dut.dq_oe_s, core_wait, core_mem_r_value == 16'd0}, 32'h3);
        end
        core_mem_request = 1'b0; i_rst = 1'b0; mem_fill = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("post_rst_idle", {30'd0, ce_n, core_wait}, 32'h3);

        // Vector table.
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].wr) exp_mem[vecs[v].addr[7:0]] = vecs[v].data;
            do_txn(vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].timing, vecs[v].data, 0, 0, lat);
            chk("latency", lat, vecs[v].exp_lat);
            e_we = 16'd0; e_oe = 16'd0; e_dq = 16'd0;
            for (int k = 1; k <= vecs[v].exp_lat + 1; k++) begin
                e_we[k] = vecs[v].wr && (k < vecs[v].exp_lat);
                e_oe[k] = !vecs[v].wr && (k < vecs[v].exp_lat);
                e_dq[k] = vecs[v].wr && (k <= vecs[v].exp_lat);
            end
            chk("we_pattern", {16'd0, tr_we}, {16'd0, e_we});
            chk("oe_pattern", {16'd0, tr_oe}, {16'd0, e_oe});
            chk("dqoe_pattern", {16'd0, tr_dqoe}, {16'd0, e_dq});
        end
        chk("r_after_write", {16'd0, core_mem_r_value}, 32'hA5A5);
        do_txn(1'b1, 20'h00077, 16'h7777, 2'd0, 16'd0, 0, 0, lat);
        exp_mem[8'h77] = 16'h7777;
        chk("r_kept_by_write", {16'd0, core_mem_r_value}, 32'hA5A5);

        // Timing changed mid-access is ignored.
        do_txn(1'b0, 20'h00044, 16'd0, 2'd3, 16'h1234, 1, 0, lat);
        chk("timing_sampled", lat, 6);

        // Request dropped after one access cycle.
        do_txn(1'b0, 20'h00001, 16'd0, 2'd0, 16'h0101, 0, 1, lat);
        chk("drop_latency", lat, 3);
        for (int c = 0; c < 4; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            chk("drop_no_access", {30'd0, oe_n, core_wait}, 32'h3);
        end

        // Back-to-back reads with request held high.
        core_mem_request = 1'b1; core_mem_wr = 1'b0; core_mem_addr = 20'd0;
        i_input_timing = 2'd0;
        sb_q.push_back(16'h0100);
        cyc = 0; last = 0; compl = 0; idle_next = 1'b0;
        while (compl < 4 && cyc < 40) begin
            @(posedge i_clk);
            @(negedge i_clk);
            cyc++;
            if (!core_wait) begin
                chk("b2b_r_value", {16'd0, core_mem_r_value}, {16'd0, sb_q.pop_front()});
                if (compl > 0) chk("b2b_period", cyc - last, 4);
                last = cyc;
                compl++;
                core_mem_addr = 20'(compl);
                if (compl < 4) sb_q.push_back(16'(16'h0100 + compl));
                idle_next = 1'b1;
            end else if (idle_next) begin
                chk("b2b_idle_oe", {31'd0, oe_n}, 32'd1);
                idle_next = 1'b0;
            end
        end
        chk("b2b_count", compl, 4);
        core_mem_request = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        @(posedge i_clk);
        @(negedge i_clk);

        // Reset during a write.
        core_mem_request = 1'b1; core_mem_wr = 1'b1; core_mem_addr = 20'h00010;
        core_mem_w_value = 16'h5555; i_input_timing = 2'd2;
        for (int c = 0; c < 2; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
        end
        chk("mid_write_we", {31'd0, we_n}, 32'd0);
        i_rst = 1'b1; core_mem_request = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_abort", {28'd0, we_n, dut.dq_oe_s, core_wait, core_mem_r_value == 16'd0}, 32'hB);
        i_rst = 1'b0;
        exp_mem[8'h10] = 16'h5555;
        @(posedge i_clk);
        @(negedge i_clk);

        // Random read/write mix against the reference memory.
        for (int i = 0; i < 1000; i++) begin
            logic        wr;
            logic [19:0] a;
            logic [15:0] wd;
            logic [1:0]  t;
            wr = 1'($urandom_range(0, 1));
            a  = 20'($urandom);
            wd = 16'($urandom);
            t  = 2'($urandom_range(0, 3));
            if (wr) exp_mem[a[7:0]] = wd;
            do_txn(wr, a, wd, t, exp_mem[a[7:0]], 0, 0, lat);
            chk("rand_latency", lat, 3 + int'(t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
